// File: rtl/bist_sig_pkg.sv
// Shared types and helpers for the BIST signature checker: FSM states,
// default signature widths and a saturating counter increment.
package bist_sig_pkg;

   localparam int DEF_MISR_SIZE = 24;
   localparam int DEF_SISA_SIZE = 16;
   localparam int DEF_CNT_W     = 8;
   localparam int SIG_W         = DEF_MISR_SIZE + DEF_SISA_SIZE;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      COMPARE = 2'd2,
      SHIFT   = 2'd3
   } state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      if (val >= max_val) begin
         return max_val;
      end else begin
         return val + 32'd1;
      end
   endfunction

endpackage

// File: rtl/sig_shift_unloader.sv
// Serial unloader for a captured signature: parallel load, MSB-first shift
// with valid/ready handshake; last_accept flags the final transferred bit.
module sig_shift_unloader #(
   parameter int W = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] data,
   input  logic         so_ready,
   output logic         so_data,
   output logic         so_valid,
   output logic         last_accept
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

   logic [W-1:0]  sh_r;
   logic [CW-1:0] cnt_r;
   logic          valid_r;

   assign last_accept = valid_r & so_ready & (cnt_r == LAST_IDX);
   assign so_data     = sh_r[W-1];
   assign so_valid    = valid_r;

   // shift register, bit counter and valid flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         sh_r    <= '0;
         cnt_r   <= '0;
         valid_r <= 1'b0;
      end else if (load) begin
         sh_r    <= data;
         cnt_r   <= '0;
         valid_r <= 1'b1;
      end else if (valid_r && so_ready) begin
         if (cnt_r == LAST_IDX) begin
            valid_r <= 1'b0;
         end else begin
            sh_r  <= {sh_r[W-2:0], 1'b0};
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

endmodule

// File: rtl/bist_signature_checker.sv
// BIST response checker: captures {MISR,SISA} on each done rise, compares it
// with the golden pair and keeps session/failure counts. Define SIG_UNLOAD_EN
// to add serial unload of the captured signature.
module bist_signature_checker
   import bist_sig_pkg::*;
#(
   parameter int MISR_SIZE = DEF_MISR_SIZE,
   parameter int SISA_SIZE = DEF_SISA_SIZE,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 golden_load,
   input  logic [MISR_SIZE-1:0] golden_misr,
   input  logic [SISA_SIZE-1:0] golden_sisa,
   input  logic                 done,
   input  logic [MISR_SIZE-1:0] misr_sig,
   input  logic [SISA_SIZE-1:0] sisa_sig,
   output logic                 armed,
   output logic                 sig_valid,
   output logic                 pass,
   output logic                 fail,
   output logic                 overrun,
   output logic [CNT_W-1:0]     sess_cnt,
   output logic [CNT_W-1:0]     fail_cnt,
   output logic                 so_data,
   output logic                 so_valid,
   input  logic                 so_ready
);

   localparam int SIG_LEN = MISR_SIZE + SISA_SIZE;
   localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

   state_t               state_r, state_s;
   logic                 done_d_r, done_rise_s;
   logic [SIG_LEN-1:0]   golden_r, cap_r;
   logic                 armed_r, sig_valid_r, pass_r, fail_r, overrun_r;
   logic [CNT_W-1:0]     sess_cnt_r, fail_cnt_r;
   logic                 capture_s, latch_s, compare_s, overrun_set_s, match_s;
   logic                 shift_done_s;

   assign done_rise_s = done & ~done_d_r;
   assign match_s     = (cap_r == golden_r);

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // next state and datapath strobes
   always_comb begin
      state_s       = state_r;
      capture_s     = 1'b0;
      latch_s       = 1'b0;
      compare_s     = 1'b0;
      overrun_set_s = 1'b0;
      case (state_r)
         IDLE: begin
            overrun_set_s = done_rise_s;
            if (golden_load) begin
               latch_s = 1'b1;
               state_s = ARMED;
            end else begin
               state_s = IDLE;
            end
         end
         ARMED: begin
            // a simultaneous golden_load is dropped: capture has priority
            if (done_rise_s) begin
               capture_s = 1'b1;
               state_s   = COMPARE;
            end else if (golden_load) begin
               latch_s = 1'b1;
            end else begin
               state_s = ARMED;
            end
         end
         COMPARE: begin
            compare_s     = 1'b1;
            overrun_set_s = done_rise_s;
`ifdef SIG_UNLOAD_EN
            state_s = SHIFT;
`else
            state_s = ARMED;
`endif
         end
         SHIFT: begin
            overrun_set_s = done_rise_s;
            if (shift_done_s) begin
               state_s = ARMED;
            end else begin
               state_s = SHIFT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // golden/capture registers, result flags and counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         done_d_r    <= 1'b0;
         golden_r    <= '0;
         cap_r       <= '0;
         armed_r     <= 1'b0;
         sig_valid_r <= 1'b0;
         pass_r      <= 1'b0;
         fail_r      <= 1'b0;
         overrun_r   <= 1'b0;
         sess_cnt_r  <= '0;
         fail_cnt_r  <= '0;
      end else begin
         done_d_r    <= done;
         armed_r     <= (state_s != IDLE);
         sig_valid_r <= compare_s;
         if (latch_s) begin
            golden_r <= {golden_misr, golden_sisa};
         end
         if (capture_s) begin
            cap_r <= {misr_sig, sisa_sig};
         end
         if (compare_s) begin
            pass_r     <= match_s;
            fail_r     <= ~match_s;
            sess_cnt_r <= CNT_W'(sat_inc(32'(sess_cnt_r), CNT_MAX));
            if (!match_s) begin
               fail_cnt_r <= CNT_W'(sat_inc(32'(fail_cnt_r), CNT_MAX));
            end
         end
         if (overrun_set_s) begin
            overrun_r <= 1'b1;
         end
      end
   end

   assign armed     = armed_r;
   assign sig_valid = sig_valid_r;
   assign pass      = pass_r;
   assign fail      = fail_r;
   assign overrun   = overrun_r;
   assign sess_cnt  = sess_cnt_r;
   assign fail_cnt  = fail_cnt_r;

`ifdef SIG_UNLOAD_EN
   sig_shift_unloader #(
      .W (SIG_LEN)
   ) u_unloader (
      .clk         (clk),
      .rst         (rst),
      .load        (compare_s),
      .data        (cap_r),
      .so_ready    (so_ready),
      .so_data     (so_data),
      .so_valid    (so_valid),
      .last_accept (shift_done_s)
   );
`else
   logic unused_so_ready_s;
   assign unused_so_ready_s = so_ready;
   assign shift_done_s      = 1'b0;
   assign so_data           = 1'b0;
   assign so_valid          = 1'b0;
`endif

endmodule
